// File: rtl/apb_pkg.sv
// APB master shared types and constants.
// State encoding, default widths, alignment mask, counter sizing.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // A limit of 0 still needs a 1-bit counter to keep ports legal.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase.
// expired flags count==limit; a zero limit never expires.
module apb_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, response out.
// Misaligned commands bypass the bus; long waits abort by timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e state;

  logic misaligned;
  logic accept;
  logic tmr_clear;
  logic tmr_en;
  logic expired;

  assign cmd_ready  = (state == ST_IDLE);
  assign misaligned = |(cmd_addr[1:0] & ALIGN_MASK);
  assign accept     = cmd_ready && cmd_valid;
  assign tmr_clear  = accept && !misaligned;
  assign tmr_en     = (state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (LIMIT),
    .expired(expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (misaligned) begin
              state       <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state   <= ST_SETUP;
              PSELx   <= 1'b1;
              PENABLE <= 1'b0;
              PWRITE  <= cmd_write;
              PADDR   <= cmd_addr;
              PWDATA  <= cmd_wdata;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          // A completion on the timeout cycle takes precedence.
          unique case (1'b1)
            PREADY: begin
              state       <= ST_RESP;
              PSELx       <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= PSLVERR;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= (PWRITE || PSLVERR) ? '0 : PRDATA;
            end
            (!PREADY && expired): begin
              state       <= ST_RESP;
              PSELx       <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
            end
            default: begin
              state <= ST_ACCESS;
            end
          endcase
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 4-cycle timeout.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_on = 1'b0;

  apb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (mon_on) begin
      chk("pen_without_sel", 64'(PENABLE & ~PSELx), 64'd0);
      chk("sel_in_resp", 64'(PSELx & rsp_valid), 64'd0);
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Cycle 0 handshake; returns in cycle 1.
  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    chk("idle_no_sel", 64'(PSELx), 64'd0);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFC;
    cmd_wdata = 32'h0BAD_0BAD;
  endtask

  task automatic setup_chk(input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    chk("setup_sel", 64'(PSELx), 64'd1);
    chk("setup_pen", 64'(PENABLE), 64'd0);
    chk("setup_pwrite", 64'(PWRITE), 64'(wr));
    chk("setup_paddr", 64'(PADDR), 64'(a));
    if (wr) chk("setup_pwdata", 64'(PWDATA), 64'(d));
    chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
  endtask

  // n ACCESS cycles; PREADY rises on the last one if last_rdy.
  task automatic access(input int n, input logic [31:0] a,
                        input logic last_rdy, input logic err,
                        input logic [31:0] rd);
    for (int i = 0; i < n; i++) begin
      chk("access_sel", 64'(PSELx), 64'd1);
      chk("access_pen", 64'(PENABLE), 64'd1);
      chk("access_paddr", 64'(PADDR), 64'(a));
      chk("access_no_rsp", 64'(rsp_valid), 64'd0);
      PREADY  = last_rdy && (i == n - 1);
      PSLVERR = err;
      PRDATA  = rd;
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h5A5A_5A5A;
  endtask

  task automatic resp_chk(input string tag, input logic [31:0] rd,
                          input logic err, input logic to);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(rd));
    chk({tag, "_err"}, 64'(rsp_err), 64'(err));
    chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(to));
    chk({tag, "_sel"}, 64'(PSELx), 64'd0);
    chk({tag, "_pen"}, 64'(PENABLE), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #3;
    chk("rst_sel", 64'(PSELx), 64'd0);
    chk("rst_pen", 64'(PENABLE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    tick();
    PRESETn = 1'b1;
    mon_on  = 1'b1;
    tick();
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write; PRDATA junk must not reach rsp_rdata.
    PRDATA = 32'hFFFF_FFFF;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    setup_chk(1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1, 32'h10, 1'b1, 1'b0, 32'hFFFF_FFFF);
    resp_chk("wr", 32'h0, 1'b0, 1'b0);

    // Read with three wait states.
    issue(1'b0, 32'h20, 32'h0);
    setup_chk(1'b0, 32'h20, 32'h0);
    access(4, 32'h20, 1'b1, 1'b0, 32'h1234_5678);
    resp_chk("rd", 32'h1234_5678, 1'b0, 1'b0);

    // Read completing with slave error.
    issue(1'b0, 32'h24, 32'h0);
    setup_chk(1'b0, 32'h24, 32'h0);
    access(1, 32'h24, 1'b1, 1'b1, 32'hAAAA_5555);
    resp_chk("slverr", 32'h0, 1'b1, 1'b0);

    // Timeout: four wait states then abort on the fifth ACCESS cycle.
    issue(1'b0, 32'h30, 32'h0);
    setup_chk(1'b0, 32'h30, 32'h0);
    access(5, 32'h30, 1'b0, 1'b0, 32'h7777_7777);
    resp_chk("tmo", 32'h0, 1'b1, 1'b1);

    // PREADY on the timeout cycle completes normally.
    issue(1'b0, 32'h34, 32'h0);
    setup_chk(1'b0, 32'h34, 32'h0);
    access(5, 32'h34, 1'b1, 1'b0, 32'hCAFE_F00D);
    resp_chk("tmo_race", 32'hCAFE_F00D, 1'b0, 1'b0);

    // Misaligned command skips the bus; response held under backpressure.
    issue(1'b1, 32'h13, 32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      chk("mis_valid", 64'(rsp_valid), 64'd1);
      chk("mis_ready", 64'(cmd_ready), 64'd0);
      chk("mis_sel", 64'(PSELx), 64'd0);
      tick();
    end
    resp_chk("mis", 32'h0, 1'b1, 1'b0);

    // Reset in ACCESS drops the transfer.
    issue(1'b0, 32'h40, 32'h0);
    tick();
    chk("pre_rst_pen", 64'(PENABLE), 64'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_sel", 64'(PSELx), 64'd0);
    chk("arst_pen", 64'(PENABLE), 64'd0);
    chk("arst_paddr", 64'(PADDR), 64'd0);
    chk("arst_pwrite", 64'(PWRITE), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    PRESETn = 1'b1;
    tick();
    chk("arst_no_rsp", 64'(rsp_valid), 64'd0);
    chk("arst_ready", 64'(cmd_ready), 64'd1);
    issue(1'b1, 32'h44, 32'h0102_0304);
    setup_chk(1'b1, 32'h44, 32'h0102_0304);
    access(2, 32'h44, 1'b1, 1'b0, 32'h0);
    resp_chk("after_rst", 32'h0, 1'b0, 1'b0);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 32: APB address width.
REQ-002 The block SHALL expose parameter DATA_W, default 32: APB data width.
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 255: maximum ACCESS wait states; 0 disables the timeout.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
REQ-005 PCLK  input  1  bus clock; all state changes on its rising edge.
REQ-006 PRESETn  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  request valid.
REQ-008 cmd_ready  output  1  request accepted when high together with cmd_valid.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_W  byte address.
REQ-011 cmd_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response valid; held until rsp_ready.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  PSLVERR, misalignment or timeout.
REQ-016 rsp_timeout  output  1  error cause was timeout.
REQ-017 PSELx, PENABLE, PWRITE  output  1 each  APB control.
REQ-018 PADDR  output  ADDR_W; PWDATA  output  DATA_W  APB address and write data.
REQ-019 PRDATA  input  DATA_W; PREADY, PSLVERR  input  1 each  completer response.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 On handshake in IDLE with cmd_addr[1:0]==0, the block SHALL latch addr, write and wdata and enter SETUP next cycle with PSELx=1 and PENABLE=0.
REQ-022 On handshake with cmd_addr[1:0]!=0, the block SHALL skip the bus and enter RESP with rsp_err=1, rsp_timeout=0 and rsp_rdata=0.
REQ-023 SETUP SHALL last exactly one cycle, then go to ACCESS with PSELx=1 and PENABLE=1.
REQ-024 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-025 In ACCESS with PREADY=0, the block SHALL stay in ACCESS and increment the wait counter.
REQ-026 In ACCESS with PREADY=1, the block SHALL capture PRDATA (reads only) and PSLVERR into rsp_rdata and rsp_err, deassert PSELx and PENABLE, and enter RESP.
REQ-027 When TIMEOUT_CYCLES>0 and the wait counter equals TIMEOUT_CYCLES with PREADY=0, the block SHALL abort: deassert PSELx and PENABLE, and enter RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-028 If PREADY=1 arrives on the timeout cycle, the completion SHALL win over the timeout.
REQ-029 rsp_valid SHALL be 1 exactly in RESP; rsp_valid and rsp_ready both high SHALL return the FSM to IDLE next cycle.
REQ-030 Minimum latency SHALL be cmd handshake at cycle 0, SETUP at 1, ACCESS at 2, and rsp_valid at 3 with zero wait states.
REQ-031 The wait counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits, SHALL clear on SETUP entry, and SHALL saturate rather than wrap.
REQ-032 PSELx SHALL never be asserted in IDLE or RESP, and PENABLE SHALL never be 1 while PSELx is 0.

Reset
REQ-033 Reset SHALL clear asynchronously: state=IDLE; PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter to 0; cmd_ready=1 after release.
REQ-034 Reset during SETUP, ACCESS or RESP SHALL drop the transfer with no response generated.

Structure
REQ-035 Package apb_pkg SHALL hold the state enum type, the default ADDR_W and DATA_W constants, and the alignment-mask constant.
REQ-036 The wait counter SHALL be a sub-module apb_wait_timer (clear, enable, limit, expired), and the FSM and datapath SHALL stay in apb_master.

Verification
REQ-037 Write 0x0000_0010 = 0xDEAD_BEEF, PREADY=1 immediately -> PSELx high cycles 1-2, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
REQ-038 Read 0x0000_0020, PREADY low 3 cycles, PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles, rsp_rdata=0x1234_5678; PADDR stable throughout.
REQ-039 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0.
REQ-040 TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 wait states, rsp_err=1, rsp_timeout=1; a variant with PREADY=1 on the 4th wait state completes normally.
REQ-041 Command to 0x0000_0013 -> no PSELx assertion, rsp_valid 1 cycle later with rsp_err=1; rsp_ready held 0 for 5 cycles keeps rsp_valid and cmd_ready=0.
REQ-042 PRESETn low during ACCESS -> all outputs 0 immediately, no rsp_valid; a new command after release completes normally.
